// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs raw fields plus a sign-extended immediate into a 32-bit word.
// Latency: one cycle from input handshake to out_valid when the output stage is empty or draining.
// Backpressure: two-entry elastic buffer (output + skid); in_ready drops only once the skid is occupied.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   in_valid / in_ready       request handshake; in_ready is driven straight from skid state
//   imm_op                    0 I, 1 S, 2 B, 3 U, 4 J, 5-7 reserved (emitted as R-type)
//   opcode, rd, funct3, rs1,
//   rs2, funct7, imm          raw instruction fields and the sign-extended immediate
//   out_valid / out_ready     encoded-word handshake
//   instruction, range_err    packed word and its "immediate not encodable" flag (qualified by out_valid)
//   instr_count               wrapping count of completed output handshakes
//
// Build option: define IMM_RANGE_CHECK_EN to enable the immediate range check; otherwise
// range_err is tied low and no check logic exists.

module instr_encoder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            imm_op,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [6:0]            funct7,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           instruction,
    output logic                  range_err,
    output logic [15:0]           instr_count
);

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Work on at least 32 bits so the U-type slice imm[31:12] always exists.
    localparam int IW = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;

    logic [IW-1:0] w_imm_x;
    logic [31:0]   w_word;
    logic          w_err;
    logic          w_accept;
    logic          w_drain;

    // Output register and skid register, each with its own valid bit.
    logic        r_out_vld;
    logic [31:0] r_out_word;
    logic        r_out_err;
    logic        r_skid_vld;
    logic [31:0] r_skid_word;
    logic        r_skid_err;
    logic [15:0] r_count;

    assign w_imm_x = IW'($signed(imm));

    // ------------------------------------------------------------------
    // Field packing
    // ------------------------------------------------------------------
    always_comb begin
        // Reserved formats fall through to R-type (no immediate).
        w_word = {funct7, rs2, rs1, funct3, rd, opcode};
        case (imm_op)
            IMM_I: w_word = {w_imm_x[11:0], rs1, funct3, rd, opcode};
            IMM_S: w_word = {w_imm_x[11:5], rs2, rs1, funct3, w_imm_x[4:0], opcode};
            IMM_B: w_word = {w_imm_x[12], w_imm_x[10:5], rs2, rs1, funct3,
                             w_imm_x[4:1], w_imm_x[11], opcode};
            IMM_U: w_word = {w_imm_x[31:12], rd, opcode};
            IMM_J: w_word = {w_imm_x[20], w_imm_x[10:1], w_imm_x[11],
                             w_imm_x[19:12], rd, opcode};
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate range check
    // ------------------------------------------------------------------
`ifdef IMM_RANGE_CHECK_EN
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;

    // An immediate fits N bits when sign-extending its low N bits reproduces it.
    assign w_fit12 = (w_imm_x == IW'($signed(w_imm_x[11:0])));
    assign w_fit13 = (w_imm_x == IW'($signed(w_imm_x[12:0])));
    assign w_fit21 = (w_imm_x == IW'($signed(w_imm_x[20:0])));

    always_comb begin
        w_err = 1'b1;
        case (imm_op)
            IMM_I,
            IMM_S:   w_err = !w_fit12;
            IMM_B:   w_err = !w_fit13 || w_imm_x[0];
            IMM_U:   w_err = (w_imm_x[11:0] != 12'd0);
            IMM_J:   w_err = !w_fit21 || w_imm_x[0];
            default: w_err = 1'b1;
        endcase
    end
`else
    assign w_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Elastic buffer
    // ------------------------------------------------------------------
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_out_vld && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld   <= 1'b0;
            r_out_word  <= 32'd0;
            r_out_err   <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_word <= 32'd0;
            r_skid_err  <= 1'b0;
            r_count     <= 16'd0;
        end else begin
            if (w_drain) begin
                r_count <= r_count + 16'd1;
            end

            if (!r_out_vld || out_ready) begin
                // Output stage is free this cycle. The skid holds the older word,
                // so it has priority; while it is full in_ready is low and no new
                // request can arrive in the same cycle.
                if (r_skid_vld) begin
                    r_out_vld  <= 1'b1;
                    r_out_word <= r_skid_word;
                    r_out_err  <= r_skid_err;
                    r_skid_vld <= 1'b0;
                end else if (w_accept) begin
                    r_out_vld  <= 1'b1;
                    r_out_word <= w_word;
                    r_out_err  <= w_err;
                end else begin
                    r_out_vld  <= 1'b0;
                end
            end else if (w_accept) begin
                // Output stalled: park the new word in the skid.
                r_skid_vld  <= 1'b1;
                r_skid_word <= w_word;
                r_skid_err  <= w_err;
            end
        end
    end

    // in_ready depends only on registered skid state, never on in_valid/out_ready.
    assign in_ready    = !r_skid_vld;
    assign out_valid   = r_out_vld;
    assign instruction = r_out_word;
    assign range_err   = r_out_err;
    assign instr_count = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_op;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic        range_err;
    logic [15:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_encoder #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .imm_op      (imm_op),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .imm         (imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instruction (instruction),
        .range_err   (range_err),
        .instr_count (instr_count)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference packing, written as shifts and masks over the format rules.
    function automatic logic [31:0] model_enc(input logic [2:0] op, input logic [6:0] opc,
                                              input logic [4:0] rdv, input logic [2:0] f3,
                                              input logic [4:0] s1, input logic [4:0] s2,
                                              input logic [6:0] f7, input logic [31:0] iv);
        logic [31:0] o, d, f, a, b, fs;
        o  = 32'(opc);
        d  = 32'(rdv) << 7;
        f  = 32'(f3) << 12;
        a  = 32'(s1) << 15;
        b  = 32'(s2) << 20;
        fs = 32'(f7) << 25;
        case (op)
            3'd0: return ((iv & 32'hFFF) << 20) | a | f | d | o;
            3'd1: return (((iv >> 5) & 32'h7F) << 25) | b | a | f | ((iv & 32'h1F) << 7) | o;
            3'd2: return (((iv >> 12) & 32'h1) << 31) | (((iv >> 5) & 32'h3F) << 25) | b | a | f
                         | (((iv >> 1) & 32'hF) << 8) | (((iv >> 11) & 32'h1) << 7) | o;
            3'd3: return (iv & 32'hFFFFF000) | d | o;
            3'd4: return (((iv >> 20) & 32'h1) << 31) | (((iv >> 1) & 32'h3FF) << 21)
                         | (((iv >> 11) & 32'h1) << 20) | (((iv >> 12) & 32'hFF) << 12) | d | o;
            default: return fs | b | a | f | d | o;
        endcase
    endfunction

    // Reference range check as signed-interval arithmetic.
    function automatic logic model_err(input logic [2:0] op, input logic [31:0] iv);
        int s;
        s = $signed(iv);
        if (!RANGE_CHK) return 1'b0;
        case (op)
            3'd0, 3'd1: return (s < -2048) || (s > 2047);
            3'd2:       return (s < -4096) || (s > 4095) || (iv % 2 != 0);
            3'd3:       return (iv % 4096) != 0;
            3'd4:       return (s < -(1 << 20)) || (s >= (1 << 20)) || (iv % 2 != 0);
            default:    return 1'b1;
        endcase
    endfunction

    task automatic set_req(input logic [2:0] op, input logic [6:0] opc, input logic [4:0] rdv,
                           input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [6:0] f7, input logic [31:0] iv);
        imm_op = op; opcode = opc; rd = rdv; funct3 = f3;
        rs1 = s1; rs2 = s2; funct7 = f7; imm = iv;
        in_valid = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [6:0]  opc;
        logic [4:0]  rdv;
        logic [2:0]  f3;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [6:0]  f7;
        logic [31:0] iv;
        logic [31:0] exp_word;
        logic        exp_err;   // value when the range check is built in
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic        e;
    } exp_t;

    vec_t vecs[7];
    exp_t q[$];

    initial begin
        logic [31:0] bnd[8];
        logic        prev_stall;
        logic [31:0] prev_word;
        logic        prev_err;
        int          hs;
        int          cyc;
        int          t;
        bit          seen_ffff;
        exp_t        e;

        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
        imm_op = 3'd0; opcode = 7'd0; rd = 5'd0; funct3 = 3'd0;
        rs1 = 5'd0; rs2 = 5'd0; funct7 = 7'd0; imm = 32'd0;

        vecs[0] = '{3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
        vecs[1] = '{3'd1, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'h00000008, 32'h0020A423, 1'b0};
        vecs[2] = '{3'd2, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
        vecs[3] = '{3'd3, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0};
        vecs[4] = '{3'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000800, 32'h80000013, 1'b1};
        vecs[5] = '{3'd4, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000003, 32'h002000EF, 1'b1};
        vecs[6] = '{3'd5, 7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'h00000000, 32'h403100B3, 1'b1};

        bnd[0] = 32'h000007FF; bnd[1] = 32'h00000800; bnd[2] = 32'hFFFFF800; bnd[3] = 32'hFFFFF7FF;
        bnd[4] = 32'h00000FFE; bnd[5] = 32'h00001000; bnd[6] = 32'h000FFFFE; bnd[7] = 32'h00100000;

        // ---------------- reset state ----------------
        do_reset();
        check1 ("rst_out_valid",   out_valid,   1'b0);
        check1 ("rst_in_ready",    in_ready,    1'b1);
        check32("rst_instruction", instruction, 32'd0);
        check1 ("rst_range_err",   range_err,   1'b0);
        check32("rst_count",       32'(instr_count), 32'd0);

        // ---------------- directed table ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_req(vecs[i].op, vecs[i].opc, vecs[i].rdv, vecs[i].f3,
                    vecs[i].s1, vecs[i].s2, vecs[i].f7, vecs[i].iv);
            check1($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            check1 ($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
            check32($sformatf("vec%0d_word", i), instruction, vecs[i].exp_word);
            check1 ($sformatf("vec%0d_range_err", i), range_err, vecs[i].exp_err & RANGE_CHK);
        end

        // ---------------- backpressure ----------------
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        set_req(3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000001);
        check1("bp_in_ready_a", in_ready, 1'b1);
        @(negedge clk);
        set_req(3'd1, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'h00000008);
        check1("bp_in_ready_b", in_ready, 1'b1);
        check1("bp_out_valid_a", out_valid, 1'b1);
        @(negedge clk);
        set_req(3'd3, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000);
        check1("bp_in_ready_c", in_ready, 1'b0);
        @(negedge clk);
        check1 ("bp_in_ready_c_held", in_ready, 1'b0);
        check32("bp_stall_word", instruction, 32'h00100093);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check32("bp_word_b", instruction, 32'h0020A423);
        check1 ("bp_valid_b", out_valid, 1'b1);
        check1 ("bp_in_ready_after", in_ready, 1'b1);
        @(negedge clk);
        check1 ("bp_empty", out_valid, 1'b0);
        check32("bp_count", 32'(instr_count), 32'd2);

        // ---------------- reset mid-operation ----------------
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        set_req(3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000001);
        @(negedge clk);
        set_req(3'd0, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000002);
        @(negedge clk);
        in_valid = 1'b0;
        check1("mid_full_valid", out_valid, 1'b1);
        check1("mid_full_ready", in_ready, 1'b0);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check1 ("mid_out_valid", out_valid, 1'b0);
        check1 ("mid_in_ready", in_ready, 1'b1);
        check32("mid_count", 32'(instr_count), 32'd0);
        check32("mid_instruction", instruction, 32'd0);
        @(negedge clk);
        check1 ("mid_discarded", out_valid, 1'b0);
        check32("mid_count_after", 32'(instr_count), 32'd0);

        // ---------------- randomized scoreboard ----------------
        do_reset();
        q.delete();
        hs = 0;
        prev_stall = 1'b0;
        prev_word  = 32'd0;
        prev_err   = 1'b0;
        for (int c = 0; c < 3200; c++) begin
            @(negedge clk);
            if (c < 3000) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
                imm_op = 3'($urandom_range(0, 7));
                opcode = 7'($urandom); rd  = 5'($urandom); funct3 = 3'($urandom);
                rs1    = 5'($urandom); rs2 = 5'($urandom); funct7 = 7'($urandom);
                case ($urandom_range(0, 4))
                    0: imm = $urandom;
                    1: begin t = int'($urandom_range(0, 9000)) - 4500; imm = 32'(t); end
                    2: imm = $urandom & 32'hFFFFF000;
                    3: imm = bnd[$urandom_range(0, 7)];
                    default: begin t = int'($urandom_range(0, 1 << 22)) - (1 << 21); imm = 32'(t); end
                endcase
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end

            check1("rnd_out_valid", out_valid, q.size() > 0);
            check1("rnd_in_ready",  in_ready,  q.size() < 2);
            if (prev_stall) begin
                check32("rnd_stall_word", instruction, prev_word);
                check1 ("rnd_stall_err",  range_err,   prev_err);
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = instruction;
            prev_err   = range_err;

            if (in_valid && in_ready) begin
                e.w = model_enc(imm_op, opcode, rd, funct3, rs1, rs2, funct7, imm);
                e.e = model_err(imm_op, imm);
                q.push_back(e);
            end
            if (out_valid && out_ready) begin
                hs++;
                if (q.size() == 0) begin
                    check1("rnd_extra_word", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    check32("rnd_word", instruction, e.w);
                    check1 ("rnd_err",  range_err,   e.e);
                end
            end
        end
        @(negedge clk);
        check32("rnd_drained", 32'(q.size()), 32'd0);
        check32("rnd_count", 32'(instr_count), 32'(hs % 65536));

        // ---------------- counter wrap ----------------
        do_reset();
        set_req(3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000001);
        out_ready = 1'b1;
        hs = 0;
        cyc = 0;
        seen_ffff = 1'b0;
        while (hs < 65536 && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            if (hs == 65535 && !seen_ffff) begin
                check32("wrap_ffff", 32'(instr_count), 32'h0000FFFF);
                seen_ffff = 1'b1;
            end
            if (out_valid && out_ready) hs++;
        end
        in_valid = 1'b0;
        check32("wrap_handshakes", 32'(hs), 32'd65536);
        @(negedge clk);
        check32("wrap_zero", 32'(instr_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the immediate input.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, source request.
REQ-005 SHALL have port in_ready, output, 1, encoder can accept a request.
REQ-006 SHALL have port imm_op, input, 3, immediate format: 0 I (isa_shared::IMM_3120), 1 S, 2 B, 3 U, 4 J, 5-7 reserved.
REQ-007 SHALL have ports opcode (7), rd (5), funct3 (3), rs1 (5), rs2 (5) and funct7 (7), all inputs, the raw instruction fields.
REQ-008 SHALL have port imm, input, DATA_WIDTH, the sign-extended immediate to pack.
REQ-009 SHALL have port out_valid, output, 1, encoded word available.
REQ-010 SHALL have port out_ready, input, 1, sink accepts the word.
REQ-011 SHALL have port instruction, output, 32, the packed RV32 word.
REQ-012 SHALL have port range_err, output, 1, the immediate is not encodable; qualified by out_valid.
REQ-013 SHALL have port instr_count, output, 16, count of completed output handshakes.

Function
REQ-014 SHALL accept a request when in_valid && in_ready and emit its word when out_valid && out_ready.
REQ-015 SHALL pack: I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-016 SHALL, for reserved imm_op, emit {funct7,rs2,rs1,funct3,rd,opcode} (R-type, no immediate).
REQ-017 SHALL register the output: an accepted request appears on instruction/out_valid exactly one cycle after acceptance when the output stage is empty or draining.
REQ-018 SHALL contain a two-entry elastic buffer (output register plus skid register), so two requests are held while out_ready is low.
REQ-019 SHALL drive in_ready = !skid_valid, sourced from a register with no combinational path from in_valid or out_ready.
REQ-020 SHALL route data on simultaneous accept and drain as follows: skid data moves to the output register when the skid is valid; otherwise the new data loads the output register directly.
REQ-021 SHALL hold instruction, range_err and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL preserve request order; no drop or duplication under any in_valid/out_ready pattern.
REQ-023 SHALL increment instr_count by one per output handshake and wrap from 0xFFFF to 0x0000.
REQ-024 SHALL compute range_err combinationally at acceptance and store it alongside the word in the buffer.

Reset
REQ-025 SHALL, on rst high at a clock edge, set out_valid=0, skid_valid=0, in_ready=1, instruction=0, range_err=0 and instr_count=0.
REQ-026 SHALL discard buffered words when reset arrives mid-operation; no handshake completes in the reset cycle.

Configuration
REQ-027 SHALL honour macro IMM_RANGE_CHECK_EN.
REQ-028 SHALL, when IMM_RANGE_CHECK_EN is defined, set range_err=1 under any of these conditions:
- imm differs from the sign-extension of its encodable bits (I/S 12 bits, B 13 bits, J 21 bits);
- imm[0]=1 for B or J;
- imm[11:0]!=0 for U;
- imm_op is reserved.
REQ-029 SHALL, without IMM_RANGE_CHECK_EN, tie range_err to 0 and synthesize no check logic; packing is unchanged.

Verification
REQ-030 I-type: opcode=0x13, rd=1, funct3=0, rs1=0, imm=0xFFFFFFFF, out_ready=1 -> instruction=0xFFF00093 one cycle later, range_err=0.
REQ-031 S/B/U: sw (opcode 0x23, f3=2, rs1=1, rs2=2, imm=8) -> 0x0020A423; beq x0,x0 imm=0xFFFFFFFC -> 0xFE000EE3; lui rd=5 imm=0x12345000 -> 0x123452B7.
REQ-032 Range check (IMM_RANGE_CHECK_EN defined): I imm=0x00000800 -> range_err=1; J imm=0x00000003 -> range_err=1; rebuilt without the macro -> both 0.
REQ-033 Backpressure: out_ready=0, three back-to-back requests -> first two accepted, in_ready=0 on third; out_ready=1 -> words emitted in order, instr_count=2.
REQ-034 Reset mid-operation: two words buffered, rst pulsed for one cycle -> out_valid=0, in_ready=1, instr_count=0 next cycle.
REQ-035 Wrap: 65536 handshakes from reset -> instr_count=0x0000.
